// File: rtl/jk_arb_pkg.sv
// Shared JK command encodings and the masked JK next-state function.
package jk_arb_pkg;

  localparam logic [1:0] JK_HOLD = 2'b00;
  localparam logic [1:0] JK_RST  = 2'b01;
  localparam logic [1:0] JK_SET  = 2'b10;
  localparam logic [1:0] JK_TGL  = 2'b11;

  // Widest bank the function supports; callers zero-extend a narrower bank (W < JK_MAX_W).
  localparam int JK_MAX_W = 64;

  function automatic logic [JK_MAX_W-1:0] jk_next(input logic [JK_MAX_W-1:0] q,
                                                  input logic [1:0]          jk,
                                                  input logic [JK_MAX_W-1:0] mask);
    logic [JK_MAX_W-1:0] nxt;
    nxt = q;
    for (int b = 0; b < JK_MAX_W; b++) begin
      if (mask[b]) begin
        case (jk)
          JK_HOLD: nxt[b] = q[b];
          JK_RST:  nxt[b] = 1'b0;
          JK_SET:  nxt[b] = 1'b1;
          JK_TGL:  nxt[b] = ~q[b];
        endcase
      end
    end
    return nxt;
  endfunction

endpackage

// File: rtl/jk_rr_arbiter.sv
// Round-robin grant over N requesters with optional grant locking (JKARB_LOCK_EN).
module jk_rr_arbiter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic [N-1:0] lock,
  output logic [N-1:0] grant,
  output logic [2:0]   winner
);

  logic [2:0] ptr_q, ptr_d;
  logic [2:0] win_nxt;
  int         win_hi, win_lo, win;

`ifdef JKARB_LOCK_EN
  logic       lock_act_q, lock_act_d;
  logic [2:0] lock_id_q, lock_id_d;
  logic       lock_hit;
`else
  logic       unused_lock;
  assign unused_lock = ^lock;
`endif

  // Cyclic search: first requester at or above the pointer, else first below it.
  always_comb begin
    win_hi = N;
    win_lo = N;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i] && (i >= int'(ptr_q))) win_hi = i;
      if (req[i] && (i <  int'(ptr_q))) win_lo = i;
    end
    win = (win_hi < N) ? win_hi : win_lo;
    grant = '0;
    for (int i = 0; i < N; i++) grant[i] = (win == i);
`ifdef JKARB_LOCK_EN
    if (lock_act_q) begin
      for (int i = 0; i < N; i++) grant[i] = req[i] && (3'(i) == lock_id_q);
    end
`endif
    if (!rst) grant = '0;
    winner = '0;
    for (int i = 0; i < N; i++) begin
      if (grant[i]) winner = 3'(i);
    end
  end

  always_comb begin
    ptr_d   = ptr_q;
    win_nxt = (winner == 3'(N - 1)) ? 3'd0 : winner + 3'd1;
`ifdef JKARB_LOCK_EN
    lock_act_d = lock_act_q;
    lock_id_d  = lock_id_q;
    lock_hit   = |(grant & lock);
    // A locking transfer freezes the pointer; an unlocking one advances it past the owner.
    if (|grant) begin
      if (lock_hit) begin
        lock_act_d = 1'b1;
        lock_id_d  = winner;
      end else begin
        lock_act_d = 1'b0;
        ptr_d      = win_nxt;
      end
    end
`else
    if (|grant) ptr_d = win_nxt;
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q      <= '0;
`ifdef JKARB_LOCK_EN
      lock_act_q <= 1'b0;
      lock_id_q  <= '0;
`endif
    end else begin
      ptr_q      <= ptr_d;
`ifdef JKARB_LOCK_EN
      lock_act_q <= lock_act_d;
      lock_id_q  <= lock_id_d;
`endif
    end
  end

endmodule

// File: rtl/jk_cmd_arbiter.sv
// Shared JK flag bank: round-robin command arbitration, one-stage apply register, bank update.
// Grant locking is built only when JKARB_LOCK_EN is defined; otherwise req_lock is ignored.
module jk_cmd_arbiter
  import jk_arb_pkg::*;
#(
  parameter int N = 4,
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req_valid,
  input  logic [2*N-1:0] req_jk,
  input  logic [W*N-1:0] req_mask,
  input  logic [N-1:0]   req_lock,
  output logic [N-1:0]   req_ready,
  output logic [W-1:0]   q,
  output logic           upd_valid,
  output logic [2:0]     upd_id
);

  logic [N-1:0]          grant;
  logic [2:0]            winner;
  logic [1:0]            sel_jk;
  logic [W-1:0]          sel_mask;

  logic                  app_vld_q;
  logic [1:0]            app_jk_q;
  logic [W-1:0]          app_mask_q;
  logic [2:0]            app_id_q;

  logic [W-1:0]          q_q, q_d;
  logic                  upd_valid_q;
  logic [2:0]            upd_id_q;
  logic [JK_MAX_W-1:0]   q_ext, mask_ext, nxt_ext;
  logic                  unused_nxt_hi;

  jk_rr_arbiter #(.N(N)) u_arb (
    .clk    (clk),
    .rst    (rst),
    .req    (req_valid),
    .lock   (req_lock),
    .grant  (grant),
    .winner (winner)
  );

  assign req_ready = grant;

  always_comb begin
    sel_jk   = '0;
    sel_mask = '0;
    for (int i = 0; i < N; i++) begin
      if (grant[i]) begin
        sel_jk   = req_jk[2*i +: 2];
        sel_mask = req_mask[W*i +: W];
      end
    end
  end

  // Apply stage: the accepted command waits here for one cycle before touching the bank.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) app_vld_q <= 1'b0;
    else      app_vld_q <= |grant;
  end

  always_ff @(posedge clk) begin
    if (|grant) begin
      app_jk_q   <= sel_jk;
      app_mask_q <= sel_mask;
      app_id_q   <= winner;
    end
  end

  always_comb begin
    q_ext            = '0;
    q_ext[W-1:0]     = q_q;
    mask_ext         = '0;
    mask_ext[W-1:0]  = app_mask_q;
    nxt_ext          = jk_next(q_ext, app_jk_q, mask_ext);
    q_d              = app_vld_q ? nxt_ext[W-1:0] : q_q;
  end

  assign unused_nxt_hi = ^nxt_ext[JK_MAX_W-1:W];

  // Bank stage: q and the update strobe change together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_q         <= '0;
      upd_valid_q <= 1'b0;
      upd_id_q    <= '0;
    end else begin
      q_q         <= q_d;
      upd_valid_q <= app_vld_q;
      if (app_vld_q) upd_id_q <= app_id_q;
    end
  end

  assign q         = q_q;
  assign upd_valid = upd_valid_q;
  assign upd_id    = upd_id_q;

endmodule

// File: tb/tb_jk_cmd_arbiter.sv
// Directed and randomized checks of jk_cmd_arbiter against a transaction-level reference model.
module tb_jk_cmd_arbiter;

  localparam int N = 4;
  localparam int W = 8;
`ifdef JKARB_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [2*N-1:0] req_jk    = '0;
  logic [W*N-1:0] req_mask  = '0;
  logic [N-1:0]   req_lock  = '0;
  logic [N-1:0]   req_ready;
  logic [W-1:0]   q;
  logic           upd_valid;
  logic [2:0]     upd_id;

  jk_cmd_arbiter #(.N(N), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_jk    (req_jk),
    .req_mask  (req_mask),
    .req_lock  (req_lock),
    .req_ready (req_ready),
    .q         (q),
    .upd_valid (upd_valid),
    .upd_id    (upd_id)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state: bank, pending apply, update outputs, pointer, lock owner (-1 = none).
  logic [W-1:0] m_q;
  bit           m_app_v;
  logic [1:0]   m_app_jk;
  logic [W-1:0] m_app_mask;
  int           m_app_id;
  bit           m_upd_v;
  int           m_upd_id;
  int           m_ptr;
  int           m_lock;
  int           last_w;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_q = '0; m_app_v = 0; m_upd_v = 0; m_upd_id = 0; m_ptr = 0; m_lock = -1;
  endfunction

  function automatic logic [W-1:0] model_apply(logic [W-1:0] cur, logic [1:0] jk, logic [W-1:0] m);
    case (jk)
      2'b01:   return cur & ~m;
      2'b10:   return cur | m;
      2'b11:   return cur ^ m;
      default: return cur;
    endcase
  endfunction

  function automatic int model_winner(logic [N-1:0] v);
    if (LOCK_EN && m_lock >= 0) return v[m_lock] ? m_lock : -1;
    for (int k = 0; k < N; k++) begin
      if (v[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  // One clock: check ready at the falling edge, advance the model at the rising edge, check outputs.
  task automatic step();
    int w;
    @(negedge clk);
    w = model_winner(req_valid);
    chk("ready", 64'(req_ready), (w < 0) ? 64'd0 : (64'd1 << w));
    @(posedge clk);
    #1;
    if (m_app_v) begin
      m_q      = model_apply(m_q, m_app_jk, m_app_mask);
      m_upd_v  = 1;
      m_upd_id = m_app_id;
    end else begin
      m_upd_v = 0;
    end
    m_app_v = (w >= 0);
    if (w >= 0) begin
      m_app_jk   = req_jk[2*w +: 2];
      m_app_mask = req_mask[W*w +: W];
      m_app_id   = w;
      if (LOCK_EN && req_lock[w]) m_lock = w;
      else begin
        m_lock = -1;
        m_ptr  = (w + 1) % N;
      end
    end
    last_w = w;
    chk("q", 64'(q), 64'(m_q));
    chk("upd_valid", 64'(upd_valid), 64'(m_upd_v));
    chk("upd_id", 64'(upd_id), 64'(m_upd_id));
  endtask

  task automatic set_req(input int i, input logic [1:0] jk, input logic [W-1:0] m, input bit lk);
    req_valid[i]        = 1'b1;
    req_jk[2*i +: 2]    = jk;
    req_mask[W*i +: W]  = m;
    req_lock[i]         = lk;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [W-1:0] q_before;
    model_reset();
    last_w = -1;

    // 1: reset state, then req0 sets every bit
    @(negedge clk);
    chk("rst_ready", 64'(req_ready), 64'd0);
    chk("rst_q", 64'(q), 64'd0);
    chk("rst_upd_valid", 64'(upd_valid), 64'd0);
    chk("rst_upd_id", 64'(upd_id), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    set_req(0, 2'b10, 8'hFF, 1'b0);
    step();
    chk("t1_grant", 64'(last_w), 64'd0);
    req_valid = '0;
    step();
    chk("t1_q", 64'(q), 64'hFF);
    chk("t1_upd", 64'({upd_valid, upd_id}), 64'({1'b1, 3'd0}));

    // 2: reach q=F0, then toggle mask 3C from req1
    set_req(1, 2'b01, 8'h0F, 1'b0);
    step();
    req_valid = '0;
    step();
    chk("t2_q_f0", 64'(q), 64'hF0);
    set_req(1, 2'b11, 8'h3C, 1'b0);
    step();
    req_valid = '0;
    step();
    chk("t2_q_cc", 64'(q), 64'hCC);
    chk("t2_upd_id", 64'(upd_id), 64'd1);

    // 3: all four valid for 8 cycles from pointer 0
    do_reset();
    set_req(0, 2'b10, 8'h01, 1'b0);
    set_req(1, 2'b10, 8'h02, 1'b0);
    set_req(2, 2'b11, 8'h10, 1'b0);
    set_req(3, 2'b01, 8'h01, 1'b0);
    for (int k = 0; k < 8; k++) begin
      step();
      chk("t3_order", 64'(last_w), 64'(k % 4));
      if (k > 0) chk("t3_upd_id", 64'(upd_id), 64'((k - 1) % 4));
    end
    req_valid = '0;
    step();
    chk("t3_last_upd_id", 64'(upd_id), 64'd3);

    // 4: hold command and empty mask leave q alone but still pulse upd_valid
    q_before = m_q;
    set_req(2, 2'b00, 8'hFF, 1'b0);
    step();
    req_valid = '0;
    step();
    chk("t4_hold_q", 64'(q), 64'(q_before));
    chk("t4_hold_upd", 64'(upd_valid), 64'd1);
    set_req(3, 2'b01, 8'h00, 1'b0);
    step();
    req_valid = '0;
    step();
    chk("t4_nomask_q", 64'(q), 64'(q_before));
    chk("t4_nomask_upd", 64'(upd_valid), 64'd1);

    // 5: reset asserted right after a command is accepted
    set_req(0, 2'b10, 8'hFF, 1'b0);
    step();
    req_valid = '0;
    step();
    set_req(2, 2'b01, 8'hFF, 1'b0);
    @(negedge clk);
    chk("t5_ready_pre", 64'(req_ready), 64'b0100);
    @(posedge clk);
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    chk("t5_q_now", 64'(q), 64'd0);
    chk("t5_upd_now", 64'(upd_valid), 64'd0);
    chk("t5_ready_in_rst", 64'(req_ready), 64'd0);
    @(posedge clk);
    #1;
    chk("t5_upd_after_edge", 64'(upd_valid), 64'd0);
    rst = 1'b1;
    req_valid = '0;
    set_req(1, 2'b10, 8'h01, 1'b0);
    set_req(3, 2'b10, 8'h80, 1'b0);
    step();
    chk("t5_ptr_restart", 64'(last_w), 64'd1);
    req_valid = '0;
    step();
    chk("t5_no_stale_apply", 64'(q), 64'h01);

    // 6: grant locking (lock build), or req_lock ignored (default build)
    do_reset();
    set_req(1, 2'b10, 8'h01, 1'b0);
    step();
    req_valid = '0;
    set_req(0, 2'b10, 8'h02, 1'b0);
    set_req(3, 2'b10, 8'h08, 1'b0);
    set_req(2, 2'b11, 8'h04, 1'b1);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("t6_locked_grant", 64'(last_w), LOCK_EN ? 64'd2 : 64'((k == 0) ? 2 : (k == 1) ? 3 : 0));
    end
    if (LOCK_EN) begin
      req_valid[2] = 1'b0;
      step();
      chk("t6_locked_idle", 64'(last_w), 64'hFFFF_FFFF_FFFF_FFFF);
      req_valid[2] = 1'b1;
      req_lock[2]  = 1'b0;
      step();
      chk("t6_unlock_grant", 64'(last_w), 64'd2);
      req_valid[2] = 1'b0;
      step();
      chk("t6_after_unlock", 64'(last_w), 64'd3);
    end
    req_valid = '0;
    req_lock  = '0;
    step();
    step();

    // Randomized traffic: each requester holds its command until granted
    do_reset();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] && ($urandom_range(1, 0) == 1))
          set_req(i, 2'($urandom), 8'($urandom), ($urandom_range(3, 0) == 0));
      end
      step();
      if (last_w >= 0) req_valid[last_w] = 1'b0;
    end
    req_valid = '0;
    step();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
